// File: rtl/coffee_brew_ctrl.sv
// Single-FSM coffee machine controller: heat, coffee pour, resumable milk pour, serve.
// Optional abort path enabled by defining COFFEE_CANCEL_EN.
module coffee_brew_ctrl #(
    parameter int HEAT_CYCLES       = 4,
    parameter int COFFEE_CYCLES     = 3,
    parameter int MILK_CYCLES       = 2,
    parameter int NEED_MILK_TIMEOUT = 8,
    parameter int ENJOY_CYCLES      = 5,
    parameter int SIZE_W            = 2,
    parameter int CNT_W             = 8,
    parameter int TMR_W             = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              agua,
    input  logic              cafe,
    input  logic              leche,
    input  logic              quiereLeche,
    input  logic [SIZE_W-1:0] size,
    input  logic              cancel,
    output logic [2:0]        TH_M,
    output logic              heater_on,
    output logic              coffee_valve,
    output logic              milk_valve,
    output logic              busy,
    output logic              order_err,
    output logic [CNT_W-1:0]  cups_served
);

    // Handshake: start is a level request sampled only in STANDBY; an accepted
    // order needs agua & cafe on that edge, otherwise order_err pulses next cycle.

    typedef enum logic [2:0] {
        ST_STANDBY     = 3'd0,
        ST_WORKING     = 3'd1,
        ST_POUR_COFFEE = 3'd2,
        ST_POUR_MILK   = 3'd3,
        ST_NEED_MILK   = 3'd4,
        ST_DONE        = 3'd5,
        ST_ENJOY       = 3'd6
    } state_t;

    localparam logic [TMR_W-1:0] HEAT_LOAD  = TMR_W'(HEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] NEED_LOAD  = TMR_W'(NEED_MILK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] ENJOY_LOAD = TMR_W'(ENJOY_CYCLES - 1);
    localparam logic [TMR_W-1:0] COFFEE_T   = TMR_W'(COFFEE_CYCLES);
    localparam logic [TMR_W-1:0] MILK_T     = TMR_W'(MILK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  milk_rem_q, milk_rem_d;
    logic              milk_l_q, milk_l_d;
    logic [SIZE_W-1:0] size_l_q, size_l_d;
    logic [CNT_W-1:0]  cups_q, cups_d;
    logic              order_err_d;
    logic              heater_q, coffee_q, milk_q, busy_q, order_err_q;

    logic [TMR_W-1:0]  size_mult;
    logic [TMR_W-1:0]  coffee_len;
    logic [TMR_W-1:0]  milk_len;
    logic [TMR_W-1:0]  timer_dec;

`ifndef COFFEE_CANCEL_EN
    logic cancel_unused;
    assign cancel_unused = cancel;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        milk_rem_d  = milk_rem_q;
        milk_l_d    = milk_l_q;
        size_l_d    = size_l_q;
        cups_d      = cups_q;
        order_err_d = 1'b0;

        size_mult  = TMR_W'(size_l_q) + TMR_ONE;
        coffee_len = COFFEE_T * size_mult;
        milk_len   = MILK_T * size_mult;
        timer_dec  = timer_q - TMR_ONE;

        case (state_q)
            ST_STANDBY: begin
                if (start) begin
                    if (agua && cafe) begin
                        state_d  = ST_WORKING;
                        timer_d  = HEAT_LOAD;
                        milk_l_d = quiereLeche;
                        size_l_d = size;
                    end else begin
                        order_err_d = 1'b1;
                    end
                end
            end
            ST_WORKING: begin
                if (timer_q == '0) begin
                    state_d = ST_POUR_COFFEE;
                    timer_d = coffee_len - TMR_ONE;
                end else begin
                    timer_d = timer_dec;
                end
            end
            ST_POUR_COFFEE: begin
                if (timer_q != '0) begin
                    timer_d = timer_dec;
                end else if (!milk_l_q) begin
                    state_d = ST_DONE;
                end else begin
                    milk_rem_d = milk_len;
                    if (leche) begin
                        state_d = ST_POUR_MILK;
                    end else begin
                        state_d = ST_NEED_MILK;
                        timer_d = NEED_LOAD;
                    end
                end
            end
            ST_POUR_MILK: begin
                // Every cycle spent with the valve open counts toward the pour,
                // so a shortage seen on the final cycle still completes the cup.
                milk_rem_d = milk_rem_q - TMR_ONE;
                if (milk_rem_q == TMR_ONE) begin
                    state_d = ST_DONE;
                end else if (!leche) begin
                    state_d = ST_NEED_MILK;
                    timer_d = NEED_LOAD;
                end
            end
            ST_NEED_MILK: begin
                if (leche) begin
                    state_d = ST_POUR_MILK;
                end else if (timer_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_dec;
                end
            end
            ST_DONE: begin
                if (cups_q != '1) begin
                    cups_d = cups_q + CNT_W'(1);
                end
                state_d = ST_ENJOY;
                timer_d = ENJOY_LOAD;
            end
            ST_ENJOY: begin
                if (timer_q == '0) begin
                    state_d = ST_STANDBY;
                end else begin
                    timer_d = timer_dec;
                end
            end
            default: begin
                state_d = ST_STANDBY;
                timer_d = '0;
            end
        endcase

`ifdef COFFEE_CANCEL_EN
        if (cancel && (state_q == ST_WORKING || state_q == ST_POUR_COFFEE ||
                       state_q == ST_POUR_MILK || state_q == ST_NEED_MILK)) begin
            state_d    = ST_STANDBY;
            timer_d    = '0;
            milk_rem_d = '0;
            milk_l_d   = 1'b0;
            size_l_d   = '0;
            cups_d     = cups_q;
        end
`endif
    end

    // Outputs are registered from the next state so they always match state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_STANDBY;
            timer_q     <= '0;
            milk_rem_q  <= '0;
            milk_l_q    <= 1'b0;
            size_l_q    <= '0;
            cups_q      <= '0;
            heater_q    <= 1'b0;
            coffee_q    <= 1'b0;
            milk_q      <= 1'b0;
            busy_q      <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            milk_rem_q  <= milk_rem_d;
            milk_l_q    <= milk_l_d;
            size_l_q    <= size_l_d;
            cups_q      <= cups_d;
            heater_q    <= (state_d == ST_WORKING);
            coffee_q    <= (state_d == ST_POUR_COFFEE);
            milk_q      <= (state_d == ST_POUR_MILK);
            busy_q      <= (state_d != ST_STANDBY);
            order_err_q <= order_err_d;
        end
    end

    assign TH_M         = state_q;
    assign heater_on    = heater_q;
    assign coffee_valve = coffee_q;
    assign milk_valve   = milk_q;
    assign busy         = busy_q;
    assign order_err    = order_err_q;
    assign cups_served  = cups_q;

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// Bench for coffee_brew_ctrl: directed cases plus randomized orders checked against
// a per-order expected status trace built from the brewing rules.
module tb_coffee_brew_ctrl;

  localparam int HEAT    = 4;
  localparam int COFFEE  = 3;
  localparam int MILK    = 2;
  localparam int NEED_TO = 8;
  localparam int ENJOY   = 5;

  logic       clk = 1'b0;
  logic       reset, start, agua, cafe, leche, quiere_leche, cancel;
  logic [1:0] size;
  logic [2:0] th_m;
  logic       heater_on, coffee_valve, milk_valve, busy, order_err;
  logic [7:0] cups_served;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cups_exp = 0;
  logic [2:0] exp_q[$];
  bit leche_arr[512];

  coffee_brew_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .agua(agua), .cafe(cafe),
    .leche(leche), .quiereLeche(quiere_leche), .size(size), .cancel(cancel),
    .TH_M(th_m), .heater_on(heater_on), .coffee_valve(coffee_valve),
    .milk_valve(milk_valve), .busy(busy), .order_err(order_err),
    .cups_served(cups_served)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vectors++;
    if (got !== expv) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input logic [2:0] code, input string tag);
    logic [3:0] outs_exp;
    outs_exp = {code == 3'd1, code == 3'd2, code == 3'd3, code != 3'd0};
    check_eq({tag, "_thm"}, 32'(th_m), 32'(code));
    check_eq({tag, "_outs"}, 32'({heater_on, coffee_valve, milk_valve, busy}), 32'(outs_exp));
    check_eq({tag, "_err"}, 32'(order_err), 32'd0);
  endtask

  // Reference: walk the order phase by phase, consulting the milk level
  // sampled at the end of each cycle, and list the status code per cycle.
  task automatic build_expected(input bit want_milk, input int sz, input int cancel_at,
                                output bit served);
    int  rem;
    int  waited;
    int  last;
    bit  pouring;
    exp_q.delete();
    repeat (HEAT) exp_q.push_back(3'd1);
    repeat (COFFEE * (sz + 1)) exp_q.push_back(3'd2);
    if (want_milk) begin
      rem = MILK * (sz + 1);
      waited = 0;
      pouring = leche_arr[exp_q.size() - 1];
      while (rem > 0) begin
        if (pouring) begin
          exp_q.push_back(3'd3);
          rem--;
          last = exp_q.size() - 1;
          if (rem > 0 && !leche_arr[last]) begin
            pouring = 1'b0;
            waited = 0;
          end
        end else begin
          exp_q.push_back(3'd4);
          waited++;
          last = exp_q.size() - 1;
          if (leche_arr[last]) pouring = 1'b1;
          else if (waited == NEED_TO) rem = 0;
        end
      end
    end
    exp_q.push_back(3'd5);
    repeat (ENJOY) exp_q.push_back(3'd6);
    exp_q.push_back(3'd0);
    served = 1'b1;
`ifdef COFFEE_CANCEL_EN
    if (cancel_at >= 0 && cancel_at < int'(exp_q.size()) &&
        exp_q[cancel_at] >= 3'd1 && exp_q[cancel_at] <= 3'd4) begin
      while (int'(exp_q.size()) > cancel_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(3'd0);
      served = 1'b0;
    end
`endif
  endtask

  // driver: place an accepted order and follow it back to STANDBY
  task automatic run_order(input bit want_milk, input int sz, input int cancel_at);
    bit served;
    int n;
    build_expected(want_milk, sz, cancel_at, served);
    n = exp_q.size();
    start = 1'b1; agua = 1'b1; cafe = 1'b1;
    quiere_leche = want_milk; size = sz[1:0]; cancel = 1'b0;
    tick();
    for (int c = 0; c < n; c++) begin
      check_status(exp_q[c], $sformatf("ord_c%0d", c));
      leche = leche_arr[c];
      cancel = (c == cancel_at);
      quiere_leche = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      agua = 1'($urandom_range(0, 1));
      cafe = 1'($urandom_range(0, 1));
      start = (c < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    cancel = 1'b0;
    if (served && cups_exp < 255) cups_exp++;
    check_eq("cups_served", 32'(cups_served), 32'(cups_exp));
  endtask

  task automatic fill_leche(input int mode);
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: leche_arr[i] = 1'b1;
        1: leche_arr[i] = 1'b0;
        2: leche_arr[i] = ($urandom_range(0, 3) != 0);
        default: leche_arr[i] = ($urandom_range(0, 1) != 0);
      endcase
    end
  endtask

  task automatic reject_start(input logic a, input logic c);
    start = 1'b1; agua = a; cafe = c;
    tick();
    start = 1'b0;
    check_eq("rej_err", 32'(order_err), 32'd1);
    check_eq("rej_thm", 32'(th_m), 32'd0);
    check_eq("rej_busy", 32'(busy), 32'd0);
    tick();
    check_eq("rej_err_clr", 32'(order_err), 32'd0);
    check_eq("rej_thm2", 32'(th_m), 32'd0);
  endtask

  initial begin
    int r;
    reset = 1'b1; start = 1'b0; agua = 1'b0; cafe = 1'b0; leche = 1'b0;
    quiere_leche = 1'b0; size = 2'd0; cancel = 1'b0;
    repeat (3) tick();
    check_status(3'd0, "rst_hold");
    check_eq("rst_cups", 32'(cups_served), 32'd0);
    reset = 1'b0;
    tick();
    check_status(3'd0, "rst_idle");

    // black coffee, smallest cup
    fill_leche(0);
    run_order(1'b0, 0, -1);
    // milk, size 2, milk always available
    run_order(1'b1, 2, -1);
    // milk wanted but never available: times out and serves black
    fill_leche(1);
    run_order(1'b1, 0, -1);
    // milk interrupted after 2 of 6 cycles, resumes 3 cycles later
    fill_leche(0);
    leche_arr[14] = 1'b0; leche_arr[15] = 1'b0; leche_arr[16] = 1'b0;
    run_order(1'b1, 2, -1);
    // milk arrives on the very cycle the wait expires
    fill_leche(1);
    leche_arr[14] = 1'b1; leche_arr[15] = 1'b1;
    run_order(1'b1, 0, -1);
    // shortage on the last milk cycle still completes
    fill_leche(0);
    leche_arr[8] = 1'b0;
    run_order(1'b1, 0, -1);

    reject_start(1'b1, 1'b0);
    reject_start(1'b0, 1'b1);

    // reset in the second coffee cycle
    start = 1'b1; agua = 1'b1; cafe = 1'b1; quiere_leche = 1'b0; size = 2'd1;
    tick();
    start = 1'b0;
    repeat (HEAT + 1) tick();
    check_eq("pre_rst_thm", 32'(th_m), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status(3'd0, "mid_rst");
    check_eq("mid_rst_cups", 32'(cups_served), 32'd0);
    cups_exp = 0;

    // cancel in the second coffee cycle
    fill_leche(0);
    run_order(1'b0, 0, HEAT + 1);

    for (int i = 0; i < 360; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 2);
        reject_start(r == 1, r == 2);
      end else begin
        fill_leche($urandom_range(0, 3));
        run_order(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 30) : -1);
      end
    end
    check_eq("cups_saturated", 32'(cups_served), 32'(cups_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
